aes_round_sequencer: RTL and testbench



---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_round_sequencer_if.sv | 29 ++
 rtl/addRoundKey.sv | 16 +
 rtl/aes_key_step.sv | 27 ++
 rtl/mixColumns.sv | 27 ++
 rtl/shiftRows.sv | 19 +
 rtl/subBytes.sv | 19 +
 rtl/aes_round_sequencer.sv | 131 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 209 ++++++++++++++++++++
 9 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
//==============================================================================
// Package  : aes_pkg
// Brief    : AES-128 shared types, S-box, round constants, FSM encodings, helpers.
// Revision : 1.0
//==============================================================================
package aes_pkg;

    typedef logic [7:0]             byte_t;
    typedef logic [31:0]            word_t;
    // [col][row]; column 0 / row 0 is the most significant byte, so a
    // 128-bit FIPS-197 hex string maps straight onto the matrix.
    typedef logic [0:3][0:3][7:0]   matrix_t;
    typedef logic [1:0]             state_t;

    localparam state_t      S_IDLE = 2'd0;
    localparam state_t      S_RUN  = 2'd1;
    localparam state_t      S_DONE = 2'd2;

    localparam logic [3:0]  NR     = 4'd10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Indexed by round number 1..10; unused slots are zero so any 4-bit index is safe.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 40'h0
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t subWord(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rotWord(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
//==============================================================================
// Interface: aes_round_sequencer_if
// Brief    : Plaintext/key input and ciphertext output handshakes of the engine.
// Revision : 1.0
//==============================================================================
interface aes_round_sequencer_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    matrix_t    in_data;
    matrix_t    in_key;
    logic       out_valid;
    logic       out_ready;
    matrix_t    out_data;
    logic       busy;

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/addRoundKey.sv
`default_nettype none
//==============================================================================
// Module   : addRoundKey
// Brief    : XOR of the state with a round key.
// Revision : 1.0
//==============================================================================
module addRoundKey
    import aes_pkg::*;
(
    input  wire matrix_t    i_state,
    input  wire matrix_t    i_key,
    output matrix_t         o_state
);
    assign o_state = i_state ^ i_key;
endmodule
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
//==============================================================================
// Module   : aes_key_step
// Brief    : Combinational AES-128 key expansion step, round key -> next round key.
// Revision : 1.0
//==============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  wire matrix_t    i_rk,
    input  wire byte_t      i_rcon,
    output matrix_t         o_rk
);
    word_t w_temp;
    word_t w_w0, w_w1, w_w2, w_w3;

    assign w_temp = subWord(rotWord(i_rk[3])) ^ {i_rcon, 24'h000000};

    // Separate words keep the w0->w1->w2->w3 ripple off a single vector.
    assign w_w0 = i_rk[0] ^ w_temp;
    assign w_w1 = i_rk[1] ^ w_w0;
    assign w_w2 = i_rk[2] ^ w_w1;
    assign w_w3 = i_rk[3] ^ w_w2;

    assign o_rk = {w_w0, w_w1, w_w2, w_w3};
endmodule
`default_nettype wire

// File: rtl/mixColumns.sv
`default_nettype none
//==============================================================================
// Module   : mixColumns
// Brief    : Per-column multiply by {02,03,01,01} circulant over GF(2^8).
// Revision : 1.0
//==============================================================================
module mixColumns
    import aes_pkg::*;
(
    input  wire matrix_t    i_state,
    output matrix_t         o_state
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        byte_t w_a0, w_a1, w_a2, w_a3;

        assign w_a0 = i_state[c][0];
        assign w_a1 = i_state[c][1];
        assign w_a2 = i_state[c][2];
        assign w_a3 = i_state[c][3];

        assign o_state[c][0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign o_state[c][1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign o_state[c][2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign o_state[c][3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
endmodule
`default_nettype wire

// File: rtl/shiftRows.sv
`default_nettype none
//==============================================================================
// Module   : shiftRows
// Brief    : Cyclic left shift of row r by r positions.
// Revision : 1.0
//==============================================================================
module shiftRows
    import aes_pkg::*;
(
    input  wire matrix_t    i_state,
    output matrix_t         o_state
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[c][r] = i_state[(c + r) % 4][r];
        end
    end
endmodule
`default_nettype wire

// File: rtl/subBytes.sv
`default_nettype none
//==============================================================================
// Module   : subBytes
// Brief    : Byte-wise S-box substitution of the state matrix.
// Revision : 1.0
//==============================================================================
module subBytes
    import aes_pkg::*;
(
    input  wire matrix_t    i_state,
    output matrix_t         o_state
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[c][r] = SBOX[i_state[c][r]];
        end
    end
endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : aes_round_sequencer
// Brief    : Iterative AES-128 encryptor, one shared round per cycle with
//            on-the-fly key expansion. Optional abort port: AES_SEQ_ABORT_EN.
// Revision : 1.0
//==============================================================================
module aes_round_sequencer
    import aes_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   rst,
`ifdef AES_SEQ_ABORT_EN
    input  wire logic                   abort,
`endif
    aes_round_sequencer_if.slave        bus
);
    state_t     r_state;
    matrix_t    r_st;
    matrix_t    r_rk;
    logic [3:0] r_rnd;

    matrix_t    w_sb;
    matrix_t    w_sr;
    matrix_t    w_mc;
    matrix_t    w_roundIn;
    matrix_t    w_roundOut;
    matrix_t    w_rkNext;
    matrix_t    w_initSt;
    logic       w_lastRound;
    logic       w_abort;

`ifdef AES_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    subBytes u_subBytes (
        .i_state    (r_st),
        .o_state    (w_sb)
    );

    shiftRows u_shiftRows (
        .i_state    (w_sb),
        .o_state    (w_sr)
    );

    mixColumns u_mixColumns (
        .i_state    (w_sr),
        .o_state    (w_mc)
    );

    aes_key_step u_keyStep (
        .i_rk       (r_rk),
        .i_rcon     (RCON[r_rnd]),
        .o_rk       (w_rkNext)
    );

    // The final round skips MixColumns.
    assign w_lastRound = (r_rnd == NR);
    assign w_roundIn   = w_lastRound ? w_sr : w_mc;

    addRoundKey u_roundArk (
        .i_state    (w_roundIn),
        .i_key      (w_rkNext),
        .o_state    (w_roundOut)
    );

    addRoundKey u_initArk (
        .i_state    (bus.in_data),
        .i_key      (bus.in_key),
        .o_state    (w_initSt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_rk    <= '0;
            r_rnd   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_st    <= w_initSt;
                        r_rk    <= bus.in_key;
                        r_rnd   <= 4'd1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_st    <= '0;
                        r_rk    <= '0;
                        r_rnd   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_st    <= w_roundOut;
                        r_rk    <= w_rkNext;
                        r_rnd   <= r_rnd + 4'd1;
                        if (w_lastRound) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Abort wins over a simultaneous output transfer.
                    if (w_abort) begin
                        r_st    <= '0;
                        r_rk    <= '0;
                        r_rnd   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_data  = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Scoreboard bench for aes_round_sequencer using FIPS-197 vectors.
// Revision : 1.0
//==============================================================================
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_Z_PT   = 128'h0;
    localparam logic [127:0] c_Z_KEY  = 128'h0;
    localparam logic [127:0] c_Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    // out_valid appears in cycle T+11, i.e. 10 edges after the accept edge.
    localparam int           c_OUT_EDGES = 10;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    aes_round_sequencer_if bus();

    aes_round_sequencer dut (
        .clk    (clk),
        .rst    (rst),
`ifdef AES_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .bus    (bus)
    );

    int             nChecks   = 0;
    int             nPass     = 0;
    int             cyc       = 0;
    int             acceptCyc = 0;
    logic [127:0]   expQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // A transfer happens on the next edge whenever valid&ready is seen mid-cycle.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready && !abort) begin
            if (expQ.size() == 0) checkVal("sbUnderflow", expQ.size(), 1);
            else                  checkVal("ciphertext", bus.out_data, expQ.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBlock(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input bit expectOut);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        checkVal("inReadyWait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        bus.in_key   = key;
        if (expectOut) expQ.push_back(ct);
        tick();
        acceptCyc    = cyc;
        bus.in_valid = 1'b0;
        checkVal("busyAfterAccept", {bus.busy, bus.in_ready}, 2'b10);
    endtask

    task automatic waitOut(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        checkVal(tag, cyc - acceptCyc, c_OUT_EDGES);
    endtask

    initial begin
        int firstAccept;
        bit seenValid;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;

        #2 rst = 1'b0;
        #1;
        checkVal("rstInReady",  bus.in_ready,  1);
        checkVal("rstOutValid", bus.out_valid, 0);
        checkVal("rstBusy",     bus.busy,      0);
        checkVal("rstOutData",  bus.out_data,  0);
        tick();
        tick();
        rst = 1'b1;

        // App. B vector, exact latency, return to IDLE one cycle later.
        sendBlock(c_B_PT, c_B_KEY, c_B_CT, 1'b1);
        waitOut("latB");
        tick();
        checkVal("readyAfterB", bus.in_ready, 1);

        // Back-to-back blocks with out_ready tied high.
        sendBlock(c_C1_PT, c_C1_KEY, c_C1_CT, 1'b1);
        firstAccept = acceptCyc;
        waitOut("latC1");
        sendBlock(c_Z_PT, c_Z_KEY, c_Z_CT, 1'b1);
        checkVal("period", acceptCyc - firstAccept, 12);
        waitOut("latZero");
        tick();

        // Backpressure for 20 cycles.
        bus.out_ready = 1'b0;
        sendBlock(c_B_PT, c_B_KEY, c_B_CT, 1'b1);
        waitOut("latBp");
        for (int i = 0; i < 20; i++) begin
            tick();
            checkVal("bpData",  bus.out_data, c_B_CT);
            checkVal("bpHold",  {bus.in_ready, bus.out_valid}, 2'b01);
        end
        bus.out_ready = 1'b1;
        tick();
        checkVal("releaseReady", bus.in_ready, 1);

        // A different vector offered mid-RUN must be ignored.
        sendBlock(c_C1_PT, c_C1_KEY, c_C1_CT, 1'b1);
        repeat (4) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = c_Z_PT;
        bus.in_key   = c_B_KEY;
        tick();
        bus.in_valid = 1'b0;
        waitOut("latIgnored");
        tick();
        checkVal("sbDrained", expQ.size(), 0);

        // Asynchronous reset in cycle T+6 discards the block.
        sendBlock(c_B_PT, c_B_KEY, c_B_CT, 1'b1);
        repeat (5) tick();
        rst = 1'b0;
        expQ.delete();
        #1;
        checkVal("midRstFlags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        checkVal("midRstData",  bus.out_data, 0);
        tick();
        rst = 1'b1;
        sendBlock(c_B_PT, c_B_KEY, c_B_CT, 1'b1);
        waitOut("latAfterRst");
        tick();

`ifdef AES_SEQ_ABORT_EN
        // Abort during cycle T+4 gives IDLE in T+5 and no output.
        sendBlock(c_B_PT, c_B_KEY, c_B_CT, 1'b0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkVal("abortIdle", {bus.in_ready, bus.busy}, 2'b10);
        checkVal("abortData", bus.out_data, 0);
        seenValid = 1'b0;
        repeat (15) begin
            tick();
            if (bus.out_valid) seenValid = 1'b1;
        end
        checkVal("abortNoValid", seenValid, 0);

        // Abort in DONE beats out_ready.
        sendBlock(c_C1_PT, c_C1_KEY, c_C1_CT, 1'b0);
        waitOut("latAbortDone");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkVal("abortDone",     {bus.out_valid, bus.in_ready}, 2'b01);
        checkVal("abortDoneData", bus.out_data, 0);
`else
        seenValid = 1'b0;
`endif

        tick();
        checkVal("sbEmpty", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", nChecks, nPass);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
